// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame sequencer.
package eth_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_HEADER   = 3'd2,
      ST_PAYLOAD  = 3'd3,
      ST_DROP     = 3'd4
   } rx_state_e;

   localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
   localparam logic [7:0]  ETH_SFD      = 8'hD5;
   localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;
   localparam int          ETH_HDR_LEN  = 14;

   // Byte idx of a MAC address in wire order (idx 0 = [47:40]).
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
      case (idx)
         3'd0:    return mac[47:40];
         3'd1:    return mac[39:32];
         3'd2:    return mac[31:24];
         3'd3:    return mac[23:16];
         3'd4:    return mac[15:8];
         default: return mac[7:0];
      endcase
   endfunction

endpackage

// File: rtl/eth_rx_sat_cnt.sv
// Saturating event counter: increments on inc_i, sticks at all-ones.
module eth_rx_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: hold at all-ones once reached.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/eth_rx_frame_ctrl.sv
// GMII receive frame sequencer: preamble/SFD strip, destination filter,
// source MAC / EtherType capture, payload streaming with sop/eop/err and
// ok/drop frame counters. Payload passes through a one-byte hold register
// so that eop lands on the last byte without look-ahead.
module eth_rx_frame_ctrl
   import eth_rx_pkg::*;
#(
   parameter int PRE_MIN  = 4,
   parameter int MAX_LEN  = 1518,
   parameter bit BCAST_EN = 1'b1
) (
   input  logic        gmii_rx_clk,
   input  logic        rst_n,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   input  logic        cfg_en,
   input  logic [47:0] cfg_local_mac,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sop,
   output logic        rx_eop,
   output logic        rx_err,
   output logic [15:0] rx_len,
   output logic [47:0] rx_src_mac,
   output logic [15:0] rx_type,
   output logic [15:0] frm_ok_cnt,
   output logic [15:0] frm_drop_cnt
);

   localparam logic [3:0]  PRE_MIN_W = 4'(PRE_MIN);
   localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
   localparam logic [3:0]  HDR_LAST  = 4'(ETH_HDR_LEN - 1);

   rx_state_e   state_q;
   logic [2:0]  pre_cnt_q;
   logic [3:0]  hdr_cnt_q;
   logic        uc_ok_q, bc_ok_q;
   logic [47:0] src_sh_q;
   logic [15:0] type_sh_q;
   logic [7:0]  hold_q;
   logic [15:0] pay_cnt_q;
   logic [7:0]  rx_data_q;
   logic        rx_valid_q, rx_sop_q, rx_eop_q, rx_err_q;
   logic [15:0] rx_len_q;
   logic [47:0] rx_src_mac_q;
   logic [15:0] rx_type_q;
   logic        ok_inc_q, drop_inc_q;

   logic [2:0]  pre_next;
   logic        sfd_ok;
   logic        uc_hit, bc_hit, dst_ok;
   logic        pay_emit, pay_end, pay_first;

   // Preamble counting, destination compare and payload end decisions.
   always_comb begin
      pre_next  = (pre_cnt_q == 3'd7) ? 3'd7 : pre_cnt_q + 3'd1;
      sfd_ok    = ({1'b0, pre_cnt_q} + 4'd1) >= PRE_MIN_W;
      uc_hit    = (gmii_rxd == mac_byte(cfg_local_mac, hdr_cnt_q[2:0]));
      bc_hit    = (gmii_rxd == mac_byte(ETH_BCAST, hdr_cnt_q[2:0]));
      dst_ok    = (uc_ok_q && uc_hit) || (BCAST_EN && bc_ok_q && bc_hit);
      // A held byte is always released in PAYLOAD: by the next byte, by dv
      // falling, or by the length limit.
      pay_emit  = (state_q == ST_PAYLOAD) && (pay_cnt_q != 16'd0);
      pay_end   = (state_q == ST_PAYLOAD) && (!gmii_rx_dv || (pay_cnt_q == MAX_LEN_W));
      pay_first = (pay_cnt_q == 16'd1);
   end

   // Frame FSM with registered payload outputs and counter event pulses.
   always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pre_cnt_q    <= '0;
         hdr_cnt_q    <= '0;
         uc_ok_q      <= 1'b0;
         bc_ok_q      <= 1'b0;
         src_sh_q     <= '0;
         type_sh_q    <= '0;
         hold_q       <= '0;
         pay_cnt_q    <= '0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         rx_sop_q     <= 1'b0;
         rx_eop_q     <= 1'b0;
         rx_err_q     <= 1'b0;
         rx_len_q     <= '0;
         rx_src_mac_q <= '0;
         rx_type_q    <= '0;
         ok_inc_q     <= 1'b0;
         drop_inc_q   <= 1'b0;
      end else begin
         rx_valid_q <= pay_emit;
         rx_sop_q   <= pay_emit && pay_first;
         rx_eop_q   <= pay_emit && pay_end;
         rx_err_q   <= pay_emit && pay_end && gmii_rx_dv;
         ok_inc_q   <= pay_emit && pay_end && !gmii_rx_dv;
         drop_inc_q <= 1'b0;
         if (pay_emit)              rx_data_q <= hold_q;
         if (pay_emit && pay_end)   rx_len_q  <= pay_cnt_q;
         if (pay_emit && pay_first) begin
            rx_src_mac_q <= src_sh_q;
            rx_type_q    <= type_sh_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (gmii_rx_dv) begin
                  if (cfg_en && (gmii_rxd == ETH_PREAMBLE)) begin
                     state_q   <= ST_PREAMBLE;
                     pre_cnt_q <= 3'd0;
                  end else begin
                     state_q <= ST_DROP;
                  end
               end
            end
            ST_PREAMBLE: begin
               if (!gmii_rx_dv) begin
                  state_q <= ST_IDLE;
               end else if (gmii_rxd == ETH_PREAMBLE) begin
                  pre_cnt_q <= pre_next;
               end else if ((gmii_rxd == ETH_SFD) && sfd_ok) begin
                  state_q   <= ST_HEADER;
                  hdr_cnt_q <= 4'd0;
                  uc_ok_q   <= 1'b1;
                  bc_ok_q   <= 1'b1;
               end else begin
                  state_q <= ST_DROP;
               end
            end
            ST_HEADER: begin
               if (!gmii_rx_dv) begin
                  state_q    <= ST_IDLE;
                  drop_inc_q <= 1'b1;
               end else begin
                  hdr_cnt_q <= hdr_cnt_q + 4'd1;
                  if (hdr_cnt_q < 4'd5) begin
                     uc_ok_q <= uc_ok_q && uc_hit;
                     bc_ok_q <= bc_ok_q && bc_hit;
                  end else if (hdr_cnt_q == 4'd5) begin
                     if (!dst_ok) begin
                        state_q    <= ST_DROP;
                        drop_inc_q <= 1'b1;
                     end
                  end else if (hdr_cnt_q < 4'd12) begin
                     src_sh_q <= {src_sh_q[39:0], gmii_rxd};
                  end else begin
                     type_sh_q <= {type_sh_q[7:0], gmii_rxd};
                  end
                  if (hdr_cnt_q == HDR_LAST) begin
                     state_q   <= ST_PAYLOAD;
                     pay_cnt_q <= 16'd0;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (pay_end) begin
                  // dv still high here means the length limit was hit.
                  state_q    <= gmii_rx_dv ? ST_DROP : ST_IDLE;
                  drop_inc_q <= gmii_rx_dv || (pay_cnt_q == 16'd0);
               end else begin
                  hold_q    <= gmii_rxd;
                  pay_cnt_q <= pay_cnt_q + 16'd1;
               end
            end
            ST_DROP: begin
               if (!gmii_rx_dv) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_sop     = rx_sop_q;
   assign rx_eop     = rx_eop_q;
   assign rx_err     = rx_err_q;
   assign rx_len     = rx_len_q;
   assign rx_src_mac = rx_src_mac_q;
   assign rx_type    = rx_type_q;

   eth_rx_sat_cnt #(.W(16)) u_ok_cnt (
      .clk   (gmii_rx_clk),
      .rst_n (rst_n),
      .inc_i (ok_inc_q),
      .cnt_o (frm_ok_cnt)
   );

   eth_rx_sat_cnt #(.W(16)) u_drop_cnt (
      .clk   (gmii_rx_clk),
      .rst_n (rst_n),
      .inc_i (drop_inc_q),
      .cnt_o (frm_drop_cnt)
   );

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl: directed frames push expected
// payload bytes into a queue, a negedge monitor pops and compares them.
module tb_eth_rx_frame_ctrl;

   localparam int          MAXL    = 64;
   localparam logic [47:0] LOCAL   = 48'h0011_2233_4455;
   localparam logic [47:0] SRC_A   = 48'hAABB_CCDD_EEFF;
   localparam logic [47:0] SRC_B   = 48'h0200_0000_0001;
   localparam logic [47:0] BAD_DST = 48'h0011_2233_4456;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n, dv, cfg_en;
   logic [7:0]  rxd;
   logic [47:0] cfg_mac;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sop, rx_eop, rx_err;
   logic [15:0] rx_len, rx_type, ok_cnt, drop_cnt;
   logic [47:0] rx_src_mac;

   typedef struct {
      logic [7:0]  d;
      logic        sop;
      logic        eop;
      logic        err;
      logic [15:0] len;
      logic [47:0] src;
      logic [15:0] typ;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] fb[$];
   int         errors  = 0;
   int         checks  = 0;
   int         n_valid = 0;
   int         nv0;

   always #5 clk = ~clk;

   eth_rx_frame_ctrl #(.PRE_MIN(4), .MAX_LEN(MAXL), .BCAST_EN(1'b1)) dut (
      .gmii_rx_clk   (clk),
      .rst_n         (rst_n),
      .gmii_rx_dv    (dv),
      .gmii_rxd      (rxd),
      .cfg_en        (cfg_en),
      .cfg_local_mac (cfg_mac),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_sop        (rx_sop),
      .rx_eop        (rx_eop),
      .rx_err        (rx_err),
      .rx_len        (rx_len),
      .rx_src_mac    (rx_src_mac),
      .rx_type       (rx_type),
      .frm_ok_cnt    (ok_cnt),
      .frm_drop_cnt  (drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] pay(input int k);
      return 8'((k * 7 + 3) & 255);
   endfunction

   task automatic build(input int npre, input logic [47:0] dst, input logic [47:0] src,
                        input logic [15:0] typ, input int npay);
      fb.delete();
      repeat (npre) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      for (int i = 0; i < 6; i++) fb.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(src[47-8*i -: 8]);
      fb.push_back(typ[15:8]);
      fb.push_back(typ[7:0]);
      for (int k = 0; k < npay; k++) fb.push_back(pay(k));
   endtask

   // Queue the bytes the DUT should deliver; nshow limits how many are seen.
   task automatic expect_pay(input int npay, input int nshow, input logic [47:0] src,
                             input logic [15:0] typ);
      int   n;
      exp_t e;
      n = (npay > MAXL) ? MAXL : npay;
      for (int k = 0; k < n && k < nshow; k++) begin
         e.d   = pay(k);
         e.sop = (k == 0);
         e.eop = (k == n - 1);
         e.err = (npay > MAXL);
         e.len = 16'(n);
         e.src = src;
         e.typ = typ;
         sb.push_back(e);
      end
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) begin
         rxd = fb[i];
         dv  = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      dv  = 1'b0;
      rxd = 8'h00;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input int ifg);
      send_n(fb.size());
      idle(ifg);
   endtask

   task automatic settle(input string name);
      idle(4);
      chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic chk_cnt(input string name, input int ok, input int drop);
      chk({name, "_ok_cnt"}, 64'(ok_cnt), 64'(ok));
      chk({name, "_drop_cnt"}, 64'(drop_cnt), 64'(drop));
   endtask

   // Monitor: every rx_valid byte must match the head of the scoreboard.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rx_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: actual data=%0h required no output", rx_data);
            end else begin
               e = sb.pop_front();
               chk("rx_data", 64'(rx_data), 64'(e.d));
               chk("rx_sop", 64'(rx_sop), 64'(e.sop));
               chk("rx_eop", 64'(rx_eop), 64'(e.eop));
               if (e.eop) begin
                  chk("rx_err", 64'(rx_err), 64'(e.err));
                  chk("rx_len", 64'(rx_len), 64'(e.len));
               end
               if (e.sop) begin
                  chk("rx_src_mac", 64'(rx_src_mac), 64'(e.src));
                  chk("rx_type", 64'(rx_type), 64'(e.typ));
               end
            end
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      dv      = 1'b0;
      rxd     = 8'h00;
      cfg_en  = 1'b1;
      cfg_mac = LOCAL;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(rx_valid), 64'd0);
      chk("rst_sop", 64'(rx_sop), 64'd0);
      chk("rst_eop", 64'(rx_eop), 64'd0);
      chk("rst_err", 64'(rx_err), 64'd0);
      chk("rst_data", 64'(rx_data), 64'd0);
      chk("rst_len", 64'(rx_len), 64'd0);
      chk("rst_src", 64'(rx_src_mac), 64'd0);
      chk("rst_type", 64'(rx_type), 64'd0);
      chk_cnt("rst", 0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Unicast frame, 46 payload + 4 FCS
      build(7, LOCAL, SRC_A, 16'h0800, 50);
      expect_pay(50, 50, SRC_A, 16'h0800);
      nv0 = n_valid;
      send(2);
      settle("uc");
      chk("uc_valid_pulses", 64'(n_valid - nv0), 64'd50);
      chk("uc_type_hold", 64'(rx_type), 64'h0800);
      chk("uc_src_hold", 64'(rx_src_mac), 64'hAABB_CCDD_EEFF);
      chk_cnt("uc", 1, 0);

      // Destination mismatch on the last address byte
      build(7, BAD_DST, SRC_A, 16'h0800, 50);
      nv0 = n_valid;
      send(2);
      settle("filt");
      chk("filt_valid_pulses", 64'(n_valid - nv0), 64'd0);
      chk_cnt("filt", 1, 1);

      // Broadcast destination
      build(7, BCAST, SRC_B, 16'h86DD, 20);
      expect_pay(20, 20, SRC_B, 16'h86DD);
      send(2);
      settle("bcast");
      chk_cnt("bcast", 2, 1);

      // SFD after only two preamble bytes
      build(2, LOCAL, SRC_A, 16'h0800, 10);
      send(2);
      settle("shortpre");
      chk_cnt("shortpre", 2, 1);

      // Corrupt preamble byte, then a good frame after a single idle cycle
      fb.delete();
      fb.push_back(8'h55); fb.push_back(8'h55); fb.push_back(8'h55); fb.push_back(8'hAB);
      repeat (10) fb.push_back(8'h55);
      send(1);
      build(7, LOCAL, SRC_A, 16'h0806, 10);
      expect_pay(10, 10, SRC_A, 16'h0806);
      send(2);
      settle("badpre");
      chk_cnt("badpre", 3, 1);

      // Oversize: truncated at MAX_LEN with error
      build(7, LOCAL, SRC_A, 16'h0800, 100);
      expect_pay(100, 100, SRC_A, 16'h0800);
      nv0 = n_valid;
      send(2);
      settle("over");
      chk("over_valid_pulses", 64'(n_valid - nv0), 64'(MAXL));
      chk_cnt("over", 3, 2);

      // dv falls at header byte 9
      build(7, LOCAL, SRC_A, 16'h0800, 0);
      send_n(8 + 9);
      idle(2);
      settle("hdrcut");
      chk_cnt("hdrcut", 3, 3);

      // Single payload byte
      build(7, LOCAL, SRC_B, 16'h0001, 1);
      expect_pay(1, 1, SRC_B, 16'h0001);
      send(2);
      settle("one");
      chk_cnt("one", 4, 3);

      // Header only, no payload
      build(7, LOCAL, SRC_A, 16'h0800, 0);
      nv0 = n_valid;
      send(2);
      settle("zero");
      chk("zero_valid_pulses", 64'(n_valid - nv0), 64'd0);
      chk_cnt("zero", 4, 4);

      // Exactly MAX_LEN bytes ends cleanly
      build(7, LOCAL, SRC_A, 16'h0800, MAXL);
      expect_pay(MAXL, MAXL, SRC_A, 16'h0800);
      send(2);
      settle("exact");
      chk_cnt("exact", 5, 4);

      // Back-to-back frames with a one-cycle gap
      build(7, LOCAL, SRC_B, 16'h1234, 5);
      expect_pay(5, 5, SRC_B, 16'h1234);
      send(1);
      build(7, LOCAL, SRC_A, 16'h0800, 7);
      expect_pay(7, 7, SRC_A, 16'h0800);
      send(2);
      settle("b2b");
      chk_cnt("b2b", 7, 4);

      // Drop counter saturation
      force dut.u_drop_cnt.cnt_q = 16'hFFFE;
      #1;
      release dut.u_drop_cnt.cnt_q;
      build(7, BAD_DST, SRC_A, 16'h0800, 4);
      send(2);
      send(2);
      settle("sat1");
      chk("sat1_drop_cnt", 64'(drop_cnt), 64'hFFFF);
      send(2);
      settle("sat2");
      chk_cnt("sat2", 7, 16'hFFFF);

      // Asynchronous reset in the middle of a payload
      build(7, LOCAL, SRC_A, 16'h0800, 30);
      expect_pay(30, 9, SRC_A, 16'h0800);
      send_n(8 + 14 + 11);
      rst_n = 1'b0;
      dv    = 1'b0;
      rxd   = 8'h00;
      #1;
      chk("arst_valid", 64'(rx_valid), 64'd0);
      chk("arst_sop", 64'(rx_sop), 64'd0);
      chk("arst_data", 64'(rx_data), 64'd0);
      chk("arst_len", 64'(rx_len), 64'd0);
      chk("arst_src", 64'(rx_src_mac), 64'd0);
      chk("arst_type", 64'(rx_type), 64'd0);
      chk_cnt("arst", 0, 0);
      chk("arst_sb_empty", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      build(7, LOCAL, SRC_B, 16'h0800, 12);
      expect_pay(12, 12, SRC_B, 16'h0800);
      send(2);
      settle("post");
      chk_cnt("post", 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
